// File: rtl/alu_issue_seq_if.sv
// Handshake, register-port and ALU-side signals of the alu_issue_seq sequencer.
// master = environment (instruction source plus external ALU); slave = sequencer.
interface alu_issue_seq_if;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic [2:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_o;
  logic        alu_carry;
  logic        done;
  logic [15:0] result;
  logic        carry_flag;

  modport master (
    output instr_valid, instr, wr_en, wr_addr, wr_data, rd_addr, alu_o, alu_carry,
    input  instr_ready, rd_data, alu_op, alu_a, alu_b, done, result, carry_flag
  );

  modport slave (
    input  instr_valid, instr, wr_en, wr_addr, wr_data, rd_addr, alu_o, alu_carry,
    output instr_ready, rd_data, alu_op, alu_a, alu_b, done, result, carry_flag
  );
endinterface

// File: rtl/alu_issue_seq.sv
// Two-cycle issue sequencer in front of a combinational 16-bit ALU with an 8 x 16 register file.
// Optional macro ALU_SEQ_BYPASS_EN forwards a same-edge external write into the operand latch.
module alu_issue_seq (
  input logic          clk,
  input logic          rst_n,
  alu_issue_seq_if.slave bus
);
  localparam int DATA_W = 16;
  localparam int NREG   = 8;

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   regs [NREG];
  logic [2:0]          op_dec, rd_dec, rs_dec, rt_dec;
  logic [3:0]          shamt_dec;
  logic                accept, wb_p1;
  logic [DATA_W-1:0]   a_sel, b_sel;
  logic [2:0]          op_p1, rd_p1;
  logic [DATA_W-1:0]   a_p1, b_p1;
  logic                done_p2, carry_p2;
  logic [DATA_W-1:0]   result_p2;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == 3'd4) || (op == 3'd5) || (op == 3'd6);
  endfunction

  // ALU carry is only meaningful for add and sub.
  function automatic logic sets_carry(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1);
  endfunction

  assign {op_dec, rd_dec, rs_dec, rt_dec, shamt_dec} = bus.instr;

  always_comb begin
    state_d         = state_q;
    bus.instr_ready = 1'b0;
    accept          = 1'b0;
    wb_p1           = 1'b0;
    case (state_q)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        wb_p1   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_sel = regs[rs_dec];
    b_sel = is_shift(op_dec) ? {12'h000, shamt_dec} : regs[rt_dec];
`ifdef ALU_SEQ_BYPASS_EN
    if (bus.wr_en && (bus.wr_addr == rs_dec)) a_sel = bus.wr_data;
    if (bus.wr_en && !is_shift(op_dec) && (bus.wr_addr == rt_dec)) b_sel = bus.wr_data;
`endif
  end

  // Stage p1: operand latch driving the ALU during EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_p1   <= '0;
      rd_p1   <= '0;
      a_p1    <= '0;
      b_p1    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_p1 <= op_dec;
        rd_p1 <= rd_dec;
        a_p1  <= a_sel;
        b_p1  <= b_sel;
      end
    end
  end

  // Stage p2: writeback capture of the ALU result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_p2   <= 1'b0;
      result_p2 <= '0;
      carry_p2  <= 1'b0;
    end else begin
      done_p2 <= wb_p1;
      if (wb_p1) result_p2 <= bus.alu_o;
      if (wb_p1 && sets_carry(op_p1)) carry_p2 <= bus.alu_carry;
    end
  end

  // Writeback takes priority over an external write to the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_p1 && (rd_p1 == 3'(i)))
          regs[i] <= bus.alu_o;
        else if (bus.wr_en && (bus.wr_addr == 3'(i)))
          regs[i] <= bus.wr_data;
      end
    end
  end

  assign bus.alu_op     = op_p1;
  assign bus.alu_a      = a_p1;
  assign bus.alu_b      = b_p1;
  assign bus.done       = done_p2;
  assign bus.result     = result_p2;
  assign bus.carry_flag = carry_p2;
  assign bus.rd_data    = regs[bus.rd_addr];
endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: behavioural ALU stand-in, register-file model, directed and random issue.
module tb_alu_issue_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  alu_issue_seq_if bus();

  alu_issue_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] mregs [8];
  logic        mcarry;
  logic [15:0] mresult;

  // {carry, result} of the ALU; carry for logic/shift/slt ops is deliberately junk.
  function automatic logic [16:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] d;
    logic [15:0] s;
    case (op)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: begin d = {1'b0, a} - {1'b0, b}; return {~d[16], d[15:0]}; end
      3'd2: return {^(a ^ b), a & b};
      3'd3: return {^(a ^ b), a | b};
      3'd4: return {^(a ^ b), a << b[3:0]};
      3'd5: return {^(a ^ b), a >> b[3:0]};
      3'd6: begin s = $signed(a) >>> b[3:0]; return {^(a ^ b), s}; end
      default: begin s = a - b; return {^(a ^ b), 15'd0, s[15]}; end
    endcase
  endfunction

  always_comb {bus.alu_carry, bus.alu_o} = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int rt, input int sh);
    logic [2:0] o3, d3, s3, t3;
    logic [3:0] h4;
    o3 = op[2:0]; d3 = rd[2:0]; s3 = rs[2:0]; t3 = rt[2:0]; h4 = sh[3:0];
    return {o3, d3, s3, t3, h4};
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr = 3'(i);
      #1;
      chk(tag, bus.rd_data, mregs[i]);
    end
  endtask

  task automatic ext_wr(input logic [2:0] addr, input logic [15:0] data);
    bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
    cyc();
    bus.wr_en = 1'b0;
    mregs[addr] = data;
    bus.rd_addr = addr;
    #1;
    chk("ext_wr_read", bus.rd_data, data);
  endtask

  // aw_*: external write on the accept edge; bw_*: external write on the writeback edge.
  task automatic issue(input logic [15:0] ins,
                       input logic aw_en, input logic [2:0] aw_addr, input logic [15:0] aw_data,
                       input logic bw_en, input logic [2:0] bw_addr, input logic [15:0] bw_data);
    logic [2:0]  op, rd, rs, rt;
    logic [3:0]  sh;
    logic [15:0] ea, eb;
    logic [16:0] r;
    logic        shift;
    int          t;
    {op, rd, rs, rt, sh} = ins;
    shift = (op >= 3'd4) && (op <= 3'd6);
    t = 0;
    while (bus.instr_ready !== 1'b1 && t < 8) begin cyc(); t++; end
    chkb("ready_before_issue", bus.instr_ready, 1'b1);
    ea = mregs[rs];
    eb = shift ? {12'h000, sh} : mregs[rt];
`ifdef ALU_SEQ_BYPASS_EN
    if (aw_en && aw_addr == rs) ea = aw_data;
    if (aw_en && !shift && aw_addr == rt) eb = aw_data;
`endif
    bus.instr = ins; bus.instr_valid = 1'b1;
    bus.wr_en = aw_en; bus.wr_addr = aw_addr; bus.wr_data = aw_data;
    cyc();
    if (aw_en) mregs[aw_addr] = aw_data;
    bus.instr_valid = 1'b0;
    bus.wr_en = bw_en; bus.wr_addr = bw_addr; bus.wr_data = bw_data;
    chkb("ready_exec", bus.instr_ready, 1'b0);
    chk("alu_op", {13'd0, bus.alu_op}, {13'd0, op});
    chk("alu_a", bus.alu_a, ea);
    chk("alu_b", bus.alu_b, eb);
    r = alu_fn(op, ea, eb);
    cyc();
    bus.wr_en = 1'b0;
    if (bw_en) mregs[bw_addr] = bw_data;
    mregs[rd] = r[15:0];
    mresult = r[15:0];
    if (op <= 3'd1) mcarry = r[16];
    chkb("done_pulse", bus.done, 1'b1);
    chk("result", bus.result, mresult);
    chkb("carry_flag", bus.carry_flag, mcarry);
    chkb("ready_after_wb", bus.instr_ready, 1'b1);
    bus.rd_addr = rd;
    #1;
    chk("rd_writeback", bus.rd_data, mregs[rd]);
    cyc();
    chkb("done_one_cycle", bus.done, 1'b0);
  endtask

  initial begin
    logic [15:0] ins, pres, ea, eb;
    logic [16:0] r;
    logic [2:0]  op, rd, rs, rt, prd;
    logic [3:0]  sh;
    logic        pcarry_upd, pend;
    logic        aw, bw;

    bus.instr_valid = 1'b0; bus.instr = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mcarry = 1'b0; mresult = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chkb("rst_ready", bus.instr_ready, 1'b1);
    chkb("rst_done", bus.done, 1'b0);
    chk("rst_result", bus.result, 16'h0);
    chkb("rst_carry", bus.carry_flag, 1'b0);
    chk("rst_alu_a", bus.alu_a, 16'h0);
    chk("rst_alu_b", bus.alu_b, 16'h0);
    chk("rst_alu_op", {13'd0, bus.alu_op}, 16'h0);
    check_regs("rst_regs");
    cyc();

    // Load and add, then sub / and (carry must stick through AND)
    ext_wr(3'd1, 16'h8000);
    ext_wr(3'd2, 16'h8001);
    issue(enc(0, 3, 1, 2, 0), 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    chk("add_r3", mregs[3], 16'h0001);
    issue(enc(1, 4, 2, 1, 0), 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    chkb("sub_carry_const", bus.carry_flag, 1'b1);
    issue(enc(2, 5, 1, 2, 0), 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    bus.rd_addr = 3'd5; #1;
    chk("and_r5_const", bus.rd_data, 16'h8000);
    chkb("and_carry_hold", bus.carry_flag, 1'b1);

    // Shifts take shamt even with rt pointing at a nonzero register
    issue(enc(6, 6, 1, 2, 4), 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    bus.rd_addr = 3'd6; #1;
    chk("sra_r6_const", bus.rd_data, 16'hF800);
    issue(enc(5, 7, 1, 2, 4), 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    bus.rd_addr = 3'd7; #1;
    chk("srl_r7_const", bus.rd_data, 16'h0800);

    // Collisions: same-index writeback wins, different index both land, accept-edge write to rs
    issue(enc(0, 3, 1, 2, 0), 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h1234);
    bus.rd_addr = 3'd3; #1;
    chk("wb_wins_r3", bus.rd_data, 16'h0001);
    issue(enc(3, 0, 1, 2, 0), 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'hBEEF);
    check_regs("diff_index_both");
    issue(enc(0, 0, 1, 2, 0), 1'b1, 3'd1, 16'h5555, 1'b0, 3'd0, 16'h0);
    check_regs("accept_edge_write");

    // Handshake: valid held high, new instruction each accept
    pend = 1'b0; prd = '0; pres = '0; pcarry_upd = 1'b0; r = '0;
    bus.instr_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c % 2 == 0) begin
        chkb("hs_ready_idle", bus.instr_ready, 1'b1);
        if (pend) begin
          chkb("hs_done", bus.done, 1'b1);
          chk("hs_result", bus.result, pres);
          mregs[prd] = pres;
          if (pcarry_upd) mcarry = r[16];
        end
        ins = 16'($urandom);
        {op, rd, rs, rt, sh} = ins;
        ea = mregs[rs];
        eb = (op >= 3'd4 && op <= 3'd6) ? {12'h000, sh} : mregs[rt];
        r = alu_fn(op, ea, eb);
        pres = r[15:0]; prd = rd; pcarry_upd = (op <= 3'd1); pend = 1'b1;
        bus.instr = ins;
      end else begin
        chkb("hs_ready_exec", bus.instr_ready, 1'b0);
        chkb("hs_done_low", bus.done, 1'b0);
        chk("hs_alu_a", bus.alu_a, ea);
        chk("hs_alu_b", bus.alu_b, eb);
      end
      cyc();
    end
    bus.instr_valid = 1'b0;
    chkb("hs_done_last", bus.done, 1'b1);
    chk("hs_result_last", bus.result, pres);
    mregs[prd] = pres;
    if (pcarry_upd) mcarry = r[16];
    chkb("hs_carry", bus.carry_flag, mcarry);
    check_regs("hs_regs");
    cyc();

    // Random instructions with random external-write collisions
    for (int k = 0; k < 8; k++) ext_wr(3'(k), 16'($urandom));
    for (int n = 0; n < 30; n++) begin
      aw = ($urandom_range(0, 2) == 0);
      bw = ($urandom_range(0, 2) == 0);
      issue(16'($urandom), aw, 3'($urandom_range(0, 7)), 16'($urandom),
            bw, 3'($urandom_range(0, 7)), 16'($urandom));
    end
    check_regs("rand_regs");

    // Reset in the middle of EXEC drops the instruction
    ext_wr(3'd1, 16'hFFFF);
    ext_wr(3'd2, 16'h0001);
    issue(enc(0, 3, 1, 2, 0), 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    bus.instr = enc(0, 4, 1, 2, 0); bus.instr_valid = 1'b1;
    cyc();
    bus.instr_valid = 1'b0;
    chkb("pre_rst_exec", bus.instr_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mcarry = 1'b0; mresult = '0;
    chkb("mid_rst_done", bus.done, 1'b0);
    chk("mid_rst_result", bus.result, 16'h0);
    chkb("mid_rst_carry", bus.carry_flag, 1'b0);
    chk("mid_rst_alu_a", bus.alu_a, 16'h0);
    check_regs("mid_rst_regs");
    cyc();
    rst_n = 1'b1;
    #1;
    chkb("post_rst_ready", bus.instr_ready, 1'b1);
    chkb("post_rst_no_wb", bus.done, 1'b0);
    check_regs("post_rst_regs");
    ext_wr(3'd1, 16'h0005);
    ext_wr(3'd2, 16'h0007);
    issue(enc(0, 3, 1, 2, 0), 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    chk("post_rst_add", mregs[3], 16'h000C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue_seq.md
# alu_issue_seq

Issue sequencer that drives the 16-bit combinational `alu` from the initiator side. It accepts 16-bit instructions over a valid/ready handshake, reads operands from an internal 8 x 16 register file, presents `op`/`i0`/`i1` to an external `alu` instance, captures `o`/`carry`, and writes the result back. It sits between the instruction source (loader or testbench) and the ALU datapath and gives the ALU a sequential, register-based front end.

## Interface
- No parameters. Width is fixed at 16 bits; the register file has 8 entries.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  instruction offered.
- `instr`  in  16  instruction word: [15:13] op, [12:10] rd, [9:7] rs, [6:4] rt, [3:0] shamt.
- `instr_ready`  out  1  sequencer can accept an instruction.
- `wr_en`  in  1  external register write.
- `wr_addr`  in  3  external write index.
- `wr_data`  in  16  external write data.
- `rd_addr`  in  3  debug read index.
- `rd_data`  out  16  combinational read of `reg[rd_addr]`.
- `alu_op`  out  3  registered; drives the ALU `op` input.
- `alu_a`  out  16  registered; drives the ALU `i0` input.
- `alu_b`  out  16  registered; drives the ALU `i1` input.
- `alu_o`  in  16  ALU result.
- `alu_carry`  in  1  ALU carry.
- `done`  out  1  one-cycle pulse after writeback.
- `result`  out  16  last written-back value.
- `carry_flag`  out  1  sticky carry from the last add or sub.

## Operation
- FSM states:
  - IDLE: `instr_ready`=1. On `instr_valid`, go to EXEC.
  - EXEC: `instr_ready`=0. Always go back to IDLE on the next edge, performing writeback on that edge.
- Accept edge (IDLE, valid=1):
  - Latch `alu_op`=op and `alu_a`=reg[rs].
  - `alu_b`=reg[rt] for op 0,1,2,3,7.
  - `alu_b`={12'h000, shamt} for op 4,5,6 (shifts).
  - Latch rd.
- Writeback edge (EXEC→IDLE):
  - reg[rd] ← `alu_o`; `result` ← `alu_o`; `done` set for exactly the following cycle.
  - `carry_flag` ← `alu_carry` only when op is 0 or 1. For op 2..7 the flag holds its value, because ALU carry is meaningless for those ops.
- Op encoding (ALU-defined): 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 sra, 7 slt (result = sign of a−b, zero-extended). Arithmetic wraps modulo 2^16.
- External writes are accepted in any state.
- Collision rules:
  - External write and writeback to the same index on the same edge: writeback wins.
  - Different indices: both writes take effect.
  - External write to rs/rt on the accept edge: operand gets the old value (read before write), unless the bypass below is compiled in.
- `instr_valid` in EXEC is ignored; the source must hold it until `instr_ready`.
- Reset (any time, including mid-EXEC):
  - Forces IDLE and clears all 8 registers.
  - `alu_op`/`alu_a`/`alu_b` = 0, `result` = 0, `carry_flag` = 0, `done` = 0, `instr_ready` = 1 once reset is released.
  - An in-flight instruction is dropped with no writeback.

## Timing
- Accept at edge N; ALU inputs are stable throughout cycle N+1; writeback at edge N+1.
- `done`, `result`, and the register update are visible in cycle N+2. Latency is 2 cycles.
- `instr_ready` returns high in cycle N+2, the same cycle as `done`. Maximum throughput is one instruction per 2 cycles.
- The ALU is combinational and must settle within one clock period. The sequencer adds no extra capture stage.
- `rd_data` reflects a write in the cycle after the write edge.

## Configuration
- `ALU_SEQ_BYPASS_EN` defined: on the accept edge, if `wr_en` and `wr_addr` equals rs (or rt, for non-shift ops), the operand latch takes `wr_data` instead of the stale register value.
- Not defined: operands always take the pre-edge register contents.
- No other behaviour differs.

## Test plan
- Reset mid-EXEC:
  - Stimulus: assert `rst_n`=0 during EXEC.
  - Required: no writeback; all registers and outputs are 0; `instr_ready`=1 after release; next instruction runs normally.
- Load and add:
  - Stimulus: write r1=0x8000, r2=0x8001; issue add r3,r1,r2.
  - Required: `alu_a`/`alu_b` = 0x8000/0x8001 in cycle N+1; r3=0x0001, `carry_flag`=1, `done` high for 1 cycle at N+2.
- Sub, then AND:
  - Stimulus: sub r4,r2,r1 (0x8001−0x8000), then and r5,r1,r2.
  - Required: r4=0x0001 with `carry_flag`=1 (no borrow); r5=0x8000 with `carry_flag` unchanged at 1.
- Shifts use shamt, not rt:
  - Stimulus: r1=0x8000; issue sra r6,r1,shamt=4, then srl r7,r1,shamt=4, with rt pointing at a nonzero register.
  - Required: `alu_b`=0x0004; r6=0xF800, r7=0x0800.
- Writeback/external-write collision:
  - Stimulus: `wr_en` to r3 (0x1234) on the same edge as writeback to r3.
  - Required: r3 holds the ALU result. Same-cycle external write to rs on the accept edge: operand = old value without `ALU_SEQ_BYPASS_EN`, new value with it.
- Handshake:
  - Stimulus: hold `instr_valid`=1 continuously with a new instruction each accept.
  - Required: accepts exactly every 2 cycles; `instr_ready`=0 in every EXEC cycle; no instruction lost or duplicated.
